// File: rtl/wb_spi_bridge.sv
// Wishbone classic slave in front of the SPI core command port: turns bus cycles into
// one-cycle core strobes, waits for the core ack with a timeout, and keeps a sticky maskable IRQ.
module wb_spi_bridge #(
    parameter int unsigned DW          = 16,
    parameter int unsigned TIMEOUT_CYC = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          wb_cyc_i,
    input  logic          wb_stb_i,
    input  logic          wb_we_i,
    input  logic [1:0]    wb_adr_i,
    input  logic [DW-1:0] wb_dat_i,
    output logic [DW-1:0] wb_dat_o,
    output logic          wb_ack_o,
    output logic          wb_err_o,
    output logic [10:0]   core_din,
    output logic          core_cmd,
    output logic          core_wr,
    output logic          core_rd,
    input  logic [8:0]    core_dout,
    input  logic          core_ack,
    input  logic          core_irq,
    output logic          irq_o
);

    localparam logic [7:0] TO_LIM = 8'(TIMEOUT_CYC);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_e;

    state_e      state_q, state_d;
    logic [1:0]  adr_q, adr_d;
    logic        we_q, we_d;
    logic [10:0] dat_q, dat_d;
    logic [10:0] din_q, din_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [8:0]  rdata_q, rdata_d;
    logic        err_q, err_d;
    logic        irq_pend_q, irq_pend_d;
    logic        irq_en_q, irq_en_d;
    logic        tflag_q, tflag_d;
    logic        irq_prev_q;

    logic        core_acc;
    logic        local_acc;
    logic        w1c;
    logic        unused_dat;

    assign unused_dat = ^wb_dat_i;
    assign core_acc   = (adr_q == 2'd1) || (adr_q == 2'd0 && we_q);
    assign local_acc  = (adr_q == 2'd2);
    assign core_din   = din_q;
    assign irq_o      = irq_pend_q & irq_en_q;

    always_comb begin
        state_d    = state_q;
        adr_d      = adr_q;
        we_d       = we_q;
        dat_d      = dat_q;
        din_d      = din_q;
        cnt_d      = cnt_q;
        rdata_d    = rdata_q;
        err_d      = err_q;
        irq_en_d   = irq_en_q;
        tflag_d    = tflag_q;
        w1c        = 1'b0;
        core_cmd   = 1'b0;
        core_wr    = 1'b0;
        core_rd    = 1'b0;
        wb_ack_o   = 1'b0;
        wb_err_o   = 1'b0;
        wb_dat_o   = '0;

        case (state_q)
            S_IDLE: begin
                if (wb_cyc_i && wb_stb_i) begin
                    adr_d = wb_adr_i;
                    we_d  = wb_we_i;
                    dat_d = wb_dat_i[10:0];
                    if (wb_we_i && wb_adr_i == 2'd0) begin
                        din_d = wb_dat_i[10:0];
                    end else if (wb_we_i && wb_adr_i == 2'd1) begin
                        din_d = {3'b000, wb_dat_i[7:0]};
                    end
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                core_cmd = we_q && (adr_q == 2'd0);
                core_wr  = we_q && (adr_q == 2'd1);
                core_rd  = !we_q && (adr_q == 2'd1);
                err_d    = 1'b0;
                rdata_d  = '0;
                if (local_acc) begin
                    rdata_d = {6'b0, tflag_q, irq_en_q, irq_pend_q};
                    if (we_q) begin
                        w1c      = dat_q[0];
                        irq_en_d = dat_q[1];
                        if (dat_q[2]) tflag_d = 1'b0;
                    end
                    state_d = S_RESP;
                end else if (!core_acc) begin
                    err_d   = 1'b1;
                    state_d = S_RESP;
                end else if (core_ack) begin
                    rdata_d = core_dout;
                    state_d = S_RESP;
                end else begin
                    cnt_d   = 8'd1;
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (core_ack) begin
                    rdata_d = core_dout;
                    state_d = S_RESP;
                end else if (cnt_q == TO_LIM) begin
                    tflag_d = 1'b1;
                    err_d   = 1'b1;
                    state_d = S_RESP;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            S_RESP: begin
                if (wb_cyc_i) begin
                    if (err_q) begin
                        wb_err_o = 1'b1;
                    end else begin
                        wb_ack_o = 1'b1;
                        wb_dat_o = {{(DW-9){1'b0}}, rdata_q};
                    end
                end
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        // Master abandoning the cycle returns us to IDLE; strobes already driven stay issued.
        if (state_q != S_IDLE && !wb_cyc_i) begin
            state_d = S_IDLE;
        end

        if (core_irq && !irq_prev_q) begin
            irq_pend_d = 1'b1;
        end else if (w1c) begin
            irq_pend_d = 1'b0;
        end else begin
            irq_pend_d = irq_pend_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            adr_q      <= '0;
            we_q       <= 1'b0;
            dat_q      <= '0;
            din_q      <= '0;
            cnt_q      <= '0;
            rdata_q    <= '0;
            err_q      <= 1'b0;
            irq_pend_q <= 1'b0;
            irq_en_q   <= 1'b0;
            tflag_q    <= 1'b0;
            irq_prev_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            adr_q      <= adr_d;
            we_q       <= we_d;
            dat_q      <= dat_d;
            din_q      <= din_d;
            cnt_q      <= cnt_d;
            rdata_q    <= rdata_d;
            err_q      <= err_d;
            irq_pend_q <= irq_pend_d;
            irq_en_q   <= irq_en_d;
            tflag_q    <= tflag_d;
            irq_prev_q <= core_irq;
        end
    end

endmodule

// File: tb/tb_wb_spi_bridge.sv
// Self-checking bench for wb_spi_bridge: bus transactions push expected responses to a
// scoreboard queue; a response monitor pops and compares them; a small core model supplies acks.
module tb_wb_spi_bridge;

    localparam int DW = 16;
    localparam int TO = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          wb_cyc_i = 1'b0;
    logic          wb_stb_i = 1'b0;
    logic          wb_we_i = 1'b0;
    logic [1:0]    wb_adr_i = '0;
    logic [DW-1:0] wb_dat_i = '0;
    logic [DW-1:0] wb_dat_o;
    logic          wb_ack_o;
    logic          wb_err_o;
    logic [10:0]   core_din;
    logic          core_cmd;
    logic          core_wr;
    logic          core_rd;
    logic [8:0]    core_dout = '0;
    logic          core_ack;
    logic          core_irq = 1'b0;
    logic          irq_o;

    always #5 clk = ~clk;

    wb_spi_bridge #(.DW(DW), .TIMEOUT_CYC(TO)) dut (
        .clk(clk), .rst(rst),
        .wb_cyc_i(wb_cyc_i), .wb_stb_i(wb_stb_i), .wb_we_i(wb_we_i),
        .wb_adr_i(wb_adr_i), .wb_dat_i(wb_dat_i), .wb_dat_o(wb_dat_o),
        .wb_ack_o(wb_ack_o), .wb_err_o(wb_err_o),
        .core_din(core_din), .core_cmd(core_cmd), .core_wr(core_wr), .core_rd(core_rd),
        .core_dout(core_dout), .core_ack(core_ack), .core_irq(core_irq), .irq_o(irq_o)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Core model: ack_mode 0 = ack with the strobe, n>0 = ack n cycles later, <0 = never.
    int   ack_mode = 0;
    logic cd_act = 1'b0;
    int   cd_cnt = 0;

    assign core_ack = ((ack_mode == 0) && (core_cmd || core_wr || core_rd)) ||
                      (cd_act && cd_cnt == 0);

    always @(posedge clk) begin
        if (rst) begin
            cd_act <= 1'b0;
        end else if ((core_cmd || core_wr || core_rd) && ack_mode > 0) begin
            cd_act <= 1'b1;
            cd_cnt <= ack_mode - 1;
        end else if (cd_act) begin
            if (cd_cnt == 0) cd_act <= 1'b0;
            else cd_cnt <= cd_cnt - 1;
        end
    end

    int          cmd_n = 0, wr_n = 0, rd_n = 0;
    logic [10:0] last_din = '0;

    always @(negedge clk) begin
        if (!rst) begin
            if (core_cmd) begin cmd_n++; last_din = core_din; end
            if (core_wr)  begin wr_n++;  last_din = core_din; end
            if (core_rd)  rd_n++;
        end
    end

    typedef struct {
        logic        err;
        logic [15:0] dat;
        logic        chk_dat;
    } exp_t;

    exp_t exp_q[$];
    int   resp_cnt = 0;
    int   stray    = 0;

    always @(negedge clk) begin
        exp_t e;
        if (wb_ack_o || wb_err_o) begin
            resp_cnt++;
            check_eq("ack_err_excl", 32'(wb_ack_o & wb_err_o), 32'd0);
            if (exp_q.size() == 0) begin
                stray++;
            end else begin
                e = exp_q.pop_front();
                check_eq("resp_err", 32'(wb_err_o), 32'(e.err));
                if (e.chk_dat) check_eq("resp_dat", 32'(wb_dat_o), 32'(e.dat));
            end
        end
    end

    task automatic wb_xfer(input logic [1:0] adr, input logic we, input logic [15:0] dat,
                           input logic exp_err, input logic [15:0] exp_dat, input logic chk_dat,
                           output int lat);
        exp_t e;
        int   n;
        logic got;
        e.err = exp_err; e.dat = exp_dat; e.chk_dat = chk_dat;
        exp_q.push_back(e);
        @(posedge clk); #1;
        wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = we; wb_adr_i = adr; wb_dat_i = dat;
        n = 0; got = 1'b0;
        while (!got && n < 64) begin
            @(negedge clk);
            n++;
            got = wb_ack_o | wb_err_o;
        end
        check_eq("resp_seen", 32'(got), 32'd1);
        if (!got && exp_q.size() > 0) void'(exp_q.pop_back());
        lat = n;
        @(posedge clk); #1;
        wb_cyc_i = 1'b0; wb_stb_i = 1'b0; wb_we_i = 1'b0;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat, c0, w0, r0, s0, rc0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check_eq("rst_ctrl", 32'({wb_ack_o, wb_err_o, core_cmd, core_wr, core_rd, irq_o}), 32'd0);
        check_eq("rst_din", 32'(core_din), 32'd0);
        check_eq("rst_dat", 32'(wb_dat_o), 32'd0);
        @(posedge clk); #1 rst = 1'b0;

        // T1: CTRL write, immediate ack
        ack_mode = 0;
        c0 = cmd_n; w0 = wr_n; r0 = rd_n;
        wb_xfer(2'd0, 1'b1, 16'h0655, 1'b0, 16'h0, 1'b0, lat);
        check_eq("t1_lat", 32'(lat), 32'd3);
        check_eq("t1_cmd", 32'(cmd_n - c0), 32'd1);
        check_eq("t1_other", 32'((wr_n - w0) + (rd_n - r0)), 32'd0);
        check_eq("t1_din", 32'(last_din), 32'h655);

        // T2: STAT read with ack 3 cycles late
        ack_mode = 3; core_dout = 9'h1A5;
        r0 = rd_n;
        wb_xfer(2'd1, 1'b0, 16'h0, 1'b0, 16'h01A5, 1'b1, lat);
        check_eq("t2_rd", 32'(rd_n - r0), 32'd1);
        check_eq("t2_lat", 32'(lat), 32'd6);

        // T3: DATA write timeout, sticky flag, clear
        ack_mode = -1;
        w0 = wr_n;
        wb_xfer(2'd1, 1'b1, 16'h12A5, 1'b1, 16'h0, 1'b1, lat);
        check_eq("t3_lat", 32'(lat), 32'd19);
        check_eq("t3_wr", 32'(wr_n - w0), 32'd1);
        check_eq("t3_din", 32'(last_din), 32'h0A5);
        ack_mode = 0;
        wb_xfer(2'd2, 1'b0, 16'h0, 1'b0, 16'h0004, 1'b1, lat);
        check_eq("t3_loc_lat", 32'(lat), 32'd3);
        wb_xfer(2'd2, 1'b0, 16'h0, 1'b0, 16'h0004, 1'b1, lat);
        wb_xfer(2'd2, 1'b1, 16'h0004, 1'b0, 16'h0, 1'b0, lat);
        wb_xfer(2'd2, 1'b0, 16'h0, 1'b0, 16'h0000, 1'b1, lat);

        // T4: interrupt set, W1C clear, set-wins collision
        wb_xfer(2'd2, 1'b1, 16'h0002, 1'b0, 16'h0, 1'b0, lat);
        @(posedge clk); #1 core_irq = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check_eq("t4_irq_set", 32'(irq_o), 32'd1);
        wb_xfer(2'd2, 1'b0, 16'h0, 1'b0, 16'h0003, 1'b1, lat);
        wb_xfer(2'd2, 1'b1, 16'h0003, 1'b0, 16'h0, 1'b0, lat);
        wb_xfer(2'd2, 1'b0, 16'h0, 1'b0, 16'h0002, 1'b1, lat);
        @(negedge clk);
        check_eq("t4_irq_clr", 32'(irq_o), 32'd0);
        @(posedge clk); #1 core_irq = 1'b0;
        repeat (2) @(posedge clk);
        fork
            wb_xfer(2'd2, 1'b1, 16'h0003, 1'b0, 16'h0, 1'b0, lat);
            begin
                @(posedge clk);
                @(posedge clk); #1 core_irq = 1'b1;
            end
        join
        @(negedge clk);
        check_eq("t4_set_wins", 32'(irq_o), 32'd1);
        wb_xfer(2'd2, 1'b0, 16'h0, 1'b0, 16'h0003, 1'b1, lat);
        wb_xfer(2'd2, 1'b1, 16'h0003, 1'b0, 16'h0, 1'b0, lat);

        // T5: bad accesses, then abort in WAIT
        s0 = cmd_n + wr_n + rd_n;
        wb_xfer(2'd0, 1'b0, 16'h0, 1'b1, 16'h0, 1'b1, lat);
        wb_xfer(2'd3, 1'b0, 16'h0, 1'b1, 16'h0, 1'b1, lat);
        wb_xfer(2'd3, 1'b1, 16'hFFFF, 1'b1, 16'h0, 1'b1, lat);
        check_eq("t5_no_strobe", 32'(cmd_n + wr_n + rd_n - s0), 32'd0);
        ack_mode = -1;
        rc0 = resp_cnt; r0 = rd_n;
        @(posedge clk); #1;
        wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = 1'b0; wb_adr_i = 2'd1;
        repeat (4) @(posedge clk);
        #1 wb_cyc_i = 1'b0; wb_stb_i = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        check_eq("t5_abort_noresp", 32'(resp_cnt - rc0), 32'd0);
        check_eq("t5_abort_rd", 32'(rd_n - r0), 32'd1);
        ack_mode = 0;
        wb_xfer(2'd2, 1'b0, 16'h0, 1'b0, 16'h0002, 1'b1, lat);
        check_eq("t5_idle_lat", 32'(lat), 32'd3);

        // T6: reset during WAIT, then a clean DATA write
        ack_mode = -1;
        rc0 = resp_cnt;
        @(posedge clk); #1;
        wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = 1'b1; wb_adr_i = 2'd1; wb_dat_i = 16'h00C3;
        repeat (4) @(posedge clk);
        #1 rst = 1'b1; wb_cyc_i = 1'b0; wb_stb_i = 1'b0; wb_we_i = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check_eq("t6_rst_ctrl", 32'({wb_ack_o, wb_err_o, core_cmd, core_wr, core_rd, irq_o}), 32'd0);
        check_eq("t6_rst_din", 32'(core_din), 32'd0);
        check_eq("t6_rst_dat", 32'(wb_dat_o), 32'd0);
        @(posedge clk); #1 rst = 1'b0;
        check_eq("t6_noresp", 32'(resp_cnt - rc0), 32'd0);
        ack_mode = 0;
        w0 = wr_n;
        wb_xfer(2'd1, 1'b1, 16'h00A5, 1'b0, 16'h0, 1'b0, lat);
        check_eq("t6_lat", 32'(lat), 32'd3);
        check_eq("t6_wr", 32'(wr_n - w0), 32'd1);
        check_eq("t6_din", 32'(last_din), 32'h0A5);

        repeat (2) @(posedge clk);
        check_eq("stray_resp", 32'(stray), 32'd0);
        check_eq("queue_empty", 32'(exp_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
